// File: rtl/sd_block_store_pkg.sv
// Shared types and status-register layout for the sd_block_store card model.
package sd_block_store_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b01,
        StBusy = 2'b10,
        StResp = 2'b11
    } state_e;

    localparam int unsigned ERR_BIT   = 7;
    localparam int unsigned STATE_LSB = 0;
    localparam int unsigned STATE_W   = 2;

endpackage

// File: rtl/sd_store_mem.sv
// Single-port synchronous RAM with write enable and registered read; storage is never reset.
module sd_store_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned AW     = 12
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sd_block_store.sv
// SD card storage model: latency-programmable ready/valid access with range checking.
// Write-protect honouring is compiled in with SD_BLOCK_STORE_WP_EN.
module sd_block_store
    import sd_block_store_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DEPTH   = 4096,
    parameter int unsigned LATENCY = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_request,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_wp_n,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_data_DV,
    output logic              o_error,
    output logic [7:0]        o_sd_card_state
);

    localparam int unsigned MemAw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW  = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CntW-1:0]   CntLoad  = CntW'((LATENCY > 1) ? LATENCY - 2 : 0);
    localparam logic [ADDR_W:0]   DepthLim = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q;
    logic              wpn_q;
    logic              err_q;
    logic              sticky_q;
    logic              rd_zero_q;

    logic              accept;
    logic              enter_resp;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata;
    logic              op_write;
    logic              op_wp_ok;
    logic              op_err;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (i_request) begin
                    if (LATENCY > 1) begin
                        state_d = StBusy;
                        cnt_d   = CntLoad;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output / datapath control. In IDLE the operation is taken straight from the inputs so
    // that LATENCY=1 can commit on the accepting edge.
    always_comb begin
        accept     = (state_q == StIdle) && i_request;
        enter_resp = (state_d == StResp);
        op_addr    = (state_q == StIdle) ? i_address : addr_q;
        op_wdata   = (state_q == StIdle) ? i_data    : wdata_q;
        op_write   = (state_q == StIdle) ? i_write   : write_q;
`ifdef SD_BLOCK_STORE_WP_EN
        op_wp_ok   = (state_q == StIdle) ? i_wp_n    : wpn_q;
`else
        op_wp_ok   = 1'b1;
`endif
        op_err     = ({1'b0, op_addr} >= DepthLim) || (op_write && !op_wp_ok);
        // Reset gating keeps a clock edge during reset from touching the unreset storage.
        mem_we     = enter_resp && op_write && !op_err && !i_rst;
        mem_re     = enter_resp && !op_write && !op_err && !i_rst;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            wpn_q     <= 1'b1;
            err_q     <= 1'b0;
            sticky_q  <= 1'b0;
            rd_zero_q <= 1'b1;
        end else begin
            if (accept) begin
                addr_q  <= i_address;
                wdata_q <= i_data;
                write_q <= i_write;
                wpn_q   <= i_wp_n;
            end
            err_q <= enter_resp && op_err;
            if (enter_resp && op_err) begin
                sticky_q <= 1'b1;
            end
            // Writes leave the previously returned read data in place.
            if (enter_resp && !op_write) begin
                rd_zero_q <= op_err;
            end
        end
    end

    sd_store_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (MemAw)
    ) u_mem (
        .clk_i   (i_clk),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (op_addr[MemAw-1:0]),
        .wdata_i (op_wdata),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        o_sd_card_state                            = '0;
        o_sd_card_state[ERR_BIT]                   = sticky_q;
        o_sd_card_state[STATE_LSB +: STATE_W]      = state_q;
    end

    assign o_ready   = (state_q == StIdle);
    assign o_data_DV = (state_q == StResp);
    assign o_error   = err_q;
    assign o_data    = rd_zero_q ? '0 : mem_rdata;

endmodule
